first_nios2_system_slave_arbiter: RTL and testbench

FIRST_NIOS2_SYSTEM_SLAVE_ARBITER -- requirements
Module: first_nios2_system_slave_arbiter

---
 rtl/first_nios2_system_slave_arbiter.sv | 114 +++++++++++
 tb/tb_first_nios2_system_slave_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/first_nios2_system_slave_arbiter.sv
// Two-master, one-slave read arbiter with round-robin grant and a fixed
// accept -> access -> response sequence. Optional grant counters: ARB_GRANT_CNT_EN.
module first_nios2_system_slave_arbiter #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_read,
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              last_gnt;
  logic              id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic winner;
  logic accept;

  // Contention goes to the master that was not granted last; a lone requester always wins.
  assign winner = (m0_read && m1_read) ? ~last_gnt : m1_read;
  assign accept = (state == IDLE) && (m0_read || m1_read);

  // Waitrequest must drop in the very cycle the request is seen, so it is
  // decoded from the registered state plus the live request lines.
  assign m0_waitrequest = !(accept && !winner);
  assign m1_waitrequest = !(accept && winner);

  assign s_read           = (state == ACCESS);
  assign s_address        = addr_q;
  assign m0_readdata      = data_q;
  assign m1_readdata      = data_q;
  assign m0_readdatavalid = (state == RESP) && !id_q;
  assign m1_readdatavalid = (state == RESP) && id_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the data and address registers are few and read-visible, so they are
  // reset explicitly; a reset mid-transaction also drops the pending response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      id_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            id_q     <= winner;
            last_gnt <= winner;
            addr_q   <= winner ? m1_address : m0_address;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          data_q <= s_readdata;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [15:0] gnt_cnt0_q;
  logic [15:0] gnt_cnt1_q;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (accept && !winner) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (accept && winner)  gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_first_nios2_system_slave_arbiter.sv
// Directed bench for first_nios2_system_slave_arbiter: a per-cycle vector table
// followed by hand-written contention, fairness and reset-abort sequences.
module tb_first_nios2_system_slave_arbiter;

  localparam logic [31:0] DATA_A1 = 32'h5AA7EC2B;

  logic        clock;
  logic        reset_n;
  logic        m0_read;
  logic [0:0]  m0_address;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic        m1_read;
  logic [0:0]  m1_address;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic        s_read;
  logic [0:0]  s_address;
  logic [31:0] s_readdata;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  first_nios2_system_slave_arbiter #(.ADDR_W(1), .DATA_W(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_read           (s_read),
    .s_address        (s_address),
    .s_readdata       (s_readdata)
`ifdef ARB_GRANT_CNT_EN
    ,
    .gnt_cnt0         (gnt_cnt0),
    .gnt_cnt1         (gnt_cnt1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Zero-wait slave: address 1 holds the signature word, address 0 reads zero.
  assign s_readdata = (s_address == 1'b1) ? DATA_A1 : 32'h0000_0000;

  typedef struct {
    logic        m0_rd;
    logic        m0_ad;
    logic        m1_rd;
    logic        m1_ad;
    logic        e_w0;
    logic        e_w1;
    logic        e_v0;
    logic        e_v1;
    logic        e_sr;
    logic        e_sa;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r0, input logic a0, input logic r1, input logic a1);
    @(negedge clock);
    m0_read    = r0;
    m0_address = a0;
    m1_read    = r1;
    m1_address = a1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n    = 1'b0;
    m0_read    = 1'b0;
    m1_read    = 1'b0;
    m0_address = 1'b0;
    m1_address = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int grants[6];
    int n_gnt;
    int budget;
    int stray_v;

    // Per-cycle table starting right after reset (last grant = m1).
    //          m0r  m0a  m1r  m1a  w0   w1   v0   v1   sr   sa   rdata
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,DATA_A1};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,DATA_A1};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,DATA_A1};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0};
    vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,DATA_A1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,DATA_A1};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,DATA_A1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0};

    reset_n    = 1'b0;
    m0_read    = 1'b0;
    m1_read    = 1'b0;
    m0_address = 1'b0;
    m1_address = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_w0",  m0_waitrequest,   1'b1);
    check("rst_w1",  m1_waitrequest,   1'b1);
    check("rst_v0",  m0_readdatavalid, 1'b0);
    check("rst_v1",  m1_readdatavalid, 1'b0);
    check("rst_rd0", m0_readdata,      32'h0);
    check("rst_rd1", m1_readdata,      32'h0);
    check("rst_sr",  s_read,           1'b0);
    check("rst_sa",  s_address,        1'b0);
`ifdef ARB_GRANT_CNT_EN
    check("rst_cnt0", gnt_cnt0, 16'h0);
    check("rst_cnt1", gnt_cnt1, 16'h0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].m0_rd, vecs[i].m0_ad, vecs[i].m1_rd, vecs[i].m1_ad);
      check($sformatf("vec%0d_w0", i),  m0_waitrequest,   vecs[i].e_w0);
      check($sformatf("vec%0d_w1", i),  m1_waitrequest,   vecs[i].e_w1);
      check($sformatf("vec%0d_v0", i),  m0_readdatavalid, vecs[i].e_v0);
      check($sformatf("vec%0d_v1", i),  m1_readdatavalid, vecs[i].e_v1);
      check($sformatf("vec%0d_sr", i),  s_read,           vecs[i].e_sr);
      check($sformatf("vec%0d_sa", i),  s_address,        vecs[i].e_sa);
      check($sformatf("vec%0d_rd0", i), m0_readdata,      vecs[i].e_rd);
      check($sformatf("vec%0d_rd1", i), m1_readdata,      vecs[i].e_rd);
    end

    // Simultaneous requests out of reset: m0 first, m1 three cycles later.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("both_t0_w0", m0_waitrequest, 1'b0);
    check("both_t0_w1", m1_waitrequest, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("both_t1_sr", s_read, 1'b1);
    check("both_t1_sa", s_address, 1'b1);
    check("both_t1_w1", m1_waitrequest, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("both_t2_v0", m0_readdatavalid, 1'b1);
    check("both_t2_v1", m1_readdatavalid, 1'b0);
    check("both_t2_rd", m0_readdata, DATA_A1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("both_t3_w1", m1_waitrequest, 1'b0);
    check("both_t3_w0", m0_waitrequest, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("both_t4_sa", s_address, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("both_t5_v1", m1_readdatavalid, 1'b1);
    check("both_t5_v0", m0_readdatavalid, 1'b0);
    check("both_t5_rd", m1_readdata, 32'h0);

    // Both masters request continuously: grants must alternate starting with m0.
    do_reset();
    n_gnt  = 0;
    budget = 0;
    while (n_gnt < 6 && budget < 60) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      if (!m0_waitrequest && !m1_waitrequest) check("rr_double_grant", 1'b1, 1'b0);
      if (!m0_waitrequest) begin
        grants[n_gnt] = 0;
        n_gnt++;
      end else if (!m1_waitrequest) begin
        grants[n_gnt] = 1;
        n_gnt++;
      end
      budget++;
    end
    check("rr_grant_count", n_gnt, 6);
    for (int g = 0; g < n_gnt; g++) begin
      check($sformatf("rr_grant%0d", g), grants[g], g % 2);
    end

    // Reset pulsed during ACCESS aborts the read; m0 is favoured afterwards.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_t0_w1", m1_waitrequest, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_t1_sr", s_read, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_rst_sr", s_read, 1'b0);
    check("abort_rst_w0", m0_waitrequest, 1'b1);
    check("abort_rst_v1", m1_readdatavalid, 1'b0);
    check("abort_rst_sa", s_address, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    stray_v = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (m0_readdatavalid || m1_readdatavalid) stray_v++;
    end
    check("abort_no_valid", stray_v, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("abort_next_w0", m0_waitrequest, 1'b0);
    check("abort_next_w1", m1_waitrequest, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_next_v0", m0_readdatavalid, 1'b1);
    check("abort_next_rd", m0_readdata, DATA_A1);

`ifdef ARB_GRANT_CNT_EN
    // Counter wrap: one m1 read, then preload m0's counter to its maximum.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("cnt1_one", gnt_cnt1, 16'd1);
    force dut.gnt_cnt0_q = 16'hFFFF;
    #1;
    release dut.gnt_cnt0_q;
    check("cnt0_preload", gnt_cnt0, 16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("cnt0_wrap", gnt_cnt0, 16'h0000);
    check("cnt1_hold", gnt_cnt1, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
